// File: rtl/rf_pkg.sv
// Shared constants, select type and busy-counter helper for the scoreboarded register file.
package rf_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 3;

  typedef logic [DefAddrW-1:0] sel_t;

  // Next pending-register count from "a clear bit got set" / "a set bit got cleared" events.
  function automatic int unsigned busy_cnt_next(int unsigned cnt, logic set_new, logic clr_old);
    int unsigned res;
    res = cnt;
    if (set_new && !clr_old) begin
      res = cnt + 1;
    end else if (!set_new && clr_old && (cnt != 0)) begin
      res = cnt - 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write flags plus a running count of pending registers.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    rsv_i,
  input  logic [ADDR_W-1:0]       sel_r_i,
  input  logic                    we_eff_i,
  input  logic [ADDR_W-1:0]       sel_d_i,
  output logic [(2**ADDR_W)-1:0]  busy_q_o,
  output logic [(2**ADDR_W)-1:0]  busy_d_o,
  output logic [ADDR_W:0]         cnt_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;

  logic [Depth-1:0] busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rsv_eff, set_new, clr_old;

  always_comb begin
    rsv_eff = rsv_i && !((ZERO_R0 != 0) && (sel_r_i == '0));
    busy_d  = busy_q;
    if (we_eff_i) busy_d[sel_d_i] = 1'b0;
    // Reserve applied last so a same-edge reserve+write to one register leaves it pending.
    if (rsv_eff) busy_d[sel_r_i] = 1'b1;
    set_new = rsv_eff && !busy_q[sel_r_i];
    clr_old = we_eff_i && busy_q[sel_d_i] && !(rsv_eff && (sel_r_i == sel_d_i));
    cnt_d   = CntW'(busy_cnt_next(32'(cnt_q), set_new, clr_old));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (en_i) begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_q_o = busy_q;
  assign busy_d_o = busy_d;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with registered reads, optional bypass and zero register,
// and a pending-write scoreboard for operand hazard detection in decode.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned BYPASS  = 1
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_en,
  input  logic              I_we,
  input  logic [ADDR_W-1:0] I_selA,
  input  logic [ADDR_W-1:0] I_selB,
  input  logic [ADDR_W-1:0] I_selD,
  input  logic [DATA_W-1:0] I_dataD,
  input  logic              I_rsv,
  input  logic [ADDR_W-1:0] I_selR,
  output logic [DATA_W-1:0] O_dataA,
  output logic [DATA_W-1:0] O_dataB,
  output logic              O_busyA,
  output logic              O_busyB,
  output logic [ADDR_W:0]   O_busy_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic              busy_a_q, busy_b_q;
  logic [Depth-1:0]  busy_cur, busy_nxt;
  logic              we_eff;

  assign we_eff = I_we && !((ZERO_R0 != 0) && (I_selD == '0));

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk_i    (I_clk),
    .rst_ni   (I_rst_n),
    .en_i     (I_en),
    .rsv_i    (I_rsv),
    .sel_r_i  (I_selR),
    .we_eff_i (we_eff),
    .sel_d_i  (I_selD),
    .busy_q_o (busy_cur),
    .busy_d_o (busy_nxt),
    .cnt_o    (O_busy_cnt)
  );

  always_comb begin
    data_a_d = regs_q[I_selA];
    data_b_d = regs_q[I_selB];
    if ((BYPASS != 0) && we_eff && (I_selD == I_selA)) data_a_d = I_dataD;
    if ((BYPASS != 0) && we_eff && (I_selD == I_selB)) data_b_d = I_dataD;
    if ((ZERO_R0 != 0) && (I_selA == '0)) data_a_d = '0;
    if ((ZERO_R0 != 0) && (I_selB == '0)) data_b_d = '0;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
    end else if (I_en && we_eff) begin
      regs_q[I_selD] <= I_dataD;
    end
  end

  // Busy outputs sample the post-edge scoreboard so a same-edge reserve is seen immediately.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      data_a_q <= '0;
      data_b_q <= '0;
      busy_a_q <= 1'b0;
      busy_b_q <= 1'b0;
    end else if (I_en) begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      busy_a_q <= busy_nxt[I_selA];
      busy_b_q <= busy_nxt[I_selB];
    end
  end

  assign O_dataA = data_a_q;
  assign O_dataB = data_b_q;
  assign O_busyA = busy_a_q;
  assign O_busyB = busy_b_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Drives three reg_file_sb configurations (default, no bypass, zero r0) with shared stimulus
// and compares each against its own behavioural model.
module tb_reg_file_sb;
  import rf_pkg::*;

  logic        I_clk, I_rst_n, I_en, I_we, I_rsv;
  logic [2:0]  I_selA, I_selB, I_selD, I_selR;
  logic [15:0] I_dataD;

  logic [15:0] o_a [3];
  logic [15:0] o_b [3];
  logic        o_ba [3];
  logic        o_bb [3];
  logic [3:0]  o_cnt [3];

  int n_vec = 0;
  int n_err = 0;

  // Model state per configuration: 0 = default, 1 = BYPASS=0, 2 = ZERO_R0=1.
  bit          cfg_byp [3] = '{1'b1, 1'b0, 1'b1};
  bit          cfg_z   [3] = '{1'b0, 1'b0, 1'b1};
  logic [15:0] m_regs [3][8];
  bit          m_busy [3][8];
  logic [15:0] m_a [3];
  logic [15:0] m_b [3];
  logic        m_ba [3];
  logic        m_bb [3];
  logic [3:0]  m_cnt [3];

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0), .BYPASS(1)) u_dut_def (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_en(I_en), .I_we(I_we), .I_selA(I_selA),
    .I_selB(I_selB), .I_selD(I_selD), .I_dataD(I_dataD), .I_rsv(I_rsv), .I_selR(I_selR),
    .O_dataA(o_a[0]), .O_dataB(o_b[0]), .O_busyA(o_ba[0]), .O_busyB(o_bb[0]),
    .O_busy_cnt(o_cnt[0])
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0), .BYPASS(0)) u_dut_nobyp (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_en(I_en), .I_we(I_we), .I_selA(I_selA),
    .I_selB(I_selB), .I_selD(I_selD), .I_dataD(I_dataD), .I_rsv(I_rsv), .I_selR(I_selR),
    .O_dataA(o_a[1]), .O_dataB(o_b[1]), .O_busyA(o_ba[1]), .O_busyB(o_bb[1]),
    .O_busy_cnt(o_cnt[1])
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1), .BYPASS(1)) u_dut_zero (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_en(I_en), .I_we(I_we), .I_selA(I_selA),
    .I_selB(I_selB), .I_selD(I_selD), .I_dataD(I_dataD), .I_rsv(I_rsv), .I_selR(I_selR),
    .O_dataA(o_a[2]), .O_dataB(o_b[2]), .O_busyA(o_ba[2]), .O_busyB(o_bb[2]),
    .O_busy_cnt(o_cnt[2])
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("cfg%0d.dataA", c), 32'(o_a[c]), 32'(m_a[c]));
      chk($sformatf("cfg%0d.dataB", c), 32'(o_b[c]), 32'(m_b[c]));
      chk($sformatf("cfg%0d.busyA", c), 32'(o_ba[c]), 32'(m_ba[c]));
      chk($sformatf("cfg%0d.busyB", c), 32'(o_bb[c]), 32'(m_bb[c]));
      chk($sformatf("cfg%0d.cnt", c), 32'(o_cnt[c]), 32'(m_cnt[c]));
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 8; r++) begin
        m_regs[c][r] = '0;
        m_busy[c][r] = 1'b0;
      end
      m_a[c] = '0; m_b[c] = '0; m_ba[c] = 1'b0; m_bb[c] = 1'b0; m_cnt[c] = '0;
    end
  endtask

  function automatic logic [15:0] model_read(int c, int sel, bit we_eff);
    if (cfg_z[c] && sel == 0) return 16'h0000;
    if (cfg_byp[c] && we_eff && int'(I_selD) == sel) return I_dataD;
    return m_regs[c][sel];
  endfunction

  task automatic model_edge();
    bit we_eff, rsv_eff;
    int pop;
    for (int c = 0; c < 3; c++) begin
      if (!I_en) continue;
      we_eff  = I_we && !(cfg_z[c] && I_selD == 3'd0);
      rsv_eff = I_rsv && !(cfg_z[c] && I_selR == 3'd0);
      m_a[c] = model_read(c, int'(I_selA), we_eff);
      m_b[c] = model_read(c, int'(I_selB), we_eff);
      if (we_eff) begin
        m_regs[c][I_selD] = I_dataD;
        m_busy[c][I_selD] = 1'b0;
      end
      if (rsv_eff) m_busy[c][I_selR] = 1'b1;
      m_ba[c] = m_busy[c][I_selA];
      m_bb[c] = m_busy[c][I_selB];
      pop = 0;
      for (int r = 0; r < 8; r++) pop += int'(m_busy[c][r]);
      m_cnt[c] = 4'(pop);
    end
  endtask

  task automatic step(input bit e, input bit w, input sel_t sd, input logic [15:0] dd,
                      input sel_t sa, input sel_t sb, input bit r, input sel_t sr);
    I_en = e; I_we = w; I_selD = sd; I_dataD = dd;
    I_selA = sa; I_selB = sb; I_rsv = r; I_selR = sr;
    @(posedge I_clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    #2 I_rst_n = 1'b0;
    #1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rst.cfg%0d.dataA", c), 32'(o_a[c]), 32'h0);
      chk($sformatf("rst.cfg%0d.cnt", c), 32'(o_cnt[c]), 32'h0);
    end
    check_all();
    #1 I_rst_n = 1'b1;
  endtask

  initial begin
    I_rst_n = 1'b0; I_en = 1'b0; I_we = 1'b0; I_rsv = 1'b0;
    I_selA = '0; I_selB = '0; I_selD = '0; I_selR = '0; I_dataD = '0;
    model_reset();
    #3;
    check_all();
    #4 I_rst_n = 1'b1;

    // Reset mid-run
    step(1, 1, 3'd0, 16'hFFFF, 3'd0, 3'd3, 0, 3'd0);
    step(1, 0, 3'd0, 16'h0000, 3'd0, 3'd3, 1, 3'd3);
    mid_reset();
    step(1, 0, 3'd0, 16'h0000, 3'd0, 3'd3, 0, 3'd0);
    chk("reset.read_r0", 32'(o_a[0]), 32'h0000);
    chk("reset.cnt", 32'(o_cnt[0]), 32'h0);

    // Bypass versus no bypass
    step(1, 1, 3'd2, 16'h2222, 3'd2, 3'd1, 0, 3'd0);
    chk("bypass.dataA", 32'(o_a[0]), 32'h2222);
    chk("nobypass.dataA_old", 32'(o_a[1]), 32'h0000);
    step(1, 0, 3'd0, 16'h0000, 3'd2, 3'd1, 0, 3'd0);
    chk("nobypass.dataA_new", 32'(o_a[1]), 32'h2222);

    // Enable gating
    for (int i = 0; i < 5; i++) step(0, 1, 3'd4, 16'h4444, 3'd4, 3'd4, 0, 3'd0);
    chk("gate.hold_dataA", 32'(o_a[0]), 32'h2222);
    step(1, 1, 3'd4, 16'h4444, 3'd4, 3'd4, 0, 3'd0);
    step(1, 0, 3'd0, 16'h0000, 3'd4, 3'd4, 0, 3'd0);
    chk("gate.r4_written", 32'(o_a[1]), 32'h4444);

    // Scoreboard
    step(1, 0, 3'd0, 16'h0000, 3'd1, 3'd2, 1, 3'd1);
    step(1, 0, 3'd0, 16'h0000, 3'd1, 3'd2, 1, 3'd2);
    chk("sb.cnt2", 32'(o_cnt[0]), 32'h2);
    chk("sb.busyA_r1", 32'(o_ba[0]), 32'h1);
    step(1, 1, 3'd1, 16'hFEED, 3'd1, 3'd2, 0, 3'd0);
    chk("sb.cnt1", 32'(o_cnt[0]), 32'h1);
    chk("sb.busyA_r1_clr", 32'(o_ba[0]), 32'h0);
    step(1, 1, 3'd2, 16'h5A5A, 3'd5, 3'd2, 1, 3'd5);
    chk("sb.net0_cnt", 32'(o_cnt[0]), 32'h1);

    // Same-register reserve + write
    step(1, 1, 3'd6, 16'h3333, 3'd6, 3'd5, 1, 3'd6);
    chk("rsvwr.busyA", 32'(o_ba[0]), 32'h1);
    chk("rsvwr.cnt", 32'(o_cnt[0]), 32'h2);
    chk("rsvwr.dataA", 32'(o_a[0]), 32'h3333);

    // Zero register
    mid_reset();
    step(1, 1, 3'd0, 16'hFFFF, 3'd0, 3'd4, 1, 3'd0);
    chk("zero.dataA", 32'(o_a[2]), 32'h0000);
    chk("zero.busyA", 32'(o_ba[2]), 32'h0);
    chk("zero.cnt", 32'(o_cnt[2]), 32'h0);
    step(1, 1, 3'd4, 16'h1234, 3'd0, 3'd0, 0, 3'd0);
    step(1, 0, 3'd0, 16'h0000, 3'd4, 3'd4, 0, 3'd0);
    chk("zero.dualA", 32'(o_a[2]), 32'h1234);
    chk("zero.dualB", 32'(o_b[2]), 32'h1234);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), 1'($urandom), 3'($urandom), 16'($urandom),
           3'($urandom), 3'($urandom), ($urandom_range(0, 2) == 0), 3'($urandom));
      if ($urandom_range(0, 59) == 0) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
